// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-master (CPU / debug-loader) arbiter in front of a single
//                handshaked memory port. One access is in flight at a time:
//                IDLE -> BUSY (wait for mem_ready or timeout) -> DONE (ack).
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    TIMEOUT      maximum BUSY cycles spent waiting for mem_ready (>= 1)
//
//  Optional feature macro
//    MEM_ARB_ROUND_ROBIN_EN  defined   : contention alternates between
//                                        masters using a last-grant register
//                            undefined : contention always goes to the CPU
//
//  Ports
//    clk, reset                     clock, synchronous active-high reset
//    cpu_req/we/addr/wdata   (in)   CPU request and its fields
//    cpu_rdata/ack/stall     (out)  CPU read data, completion pulse, stall
//    dbg_req/we/addr/wdata   (in)   debug request and its fields
//    dbg_rdata/ack           (out)  debug read data, completion pulse
//    mem_en/we/addr/wdata    (out)  memory access strobe and fields
//    mem_rdata, mem_ready    (in)   memory read data and completion
//    timeout_err             (out)  sticky flag: memory never answered
// ============================================================================
module mem_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_stall,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic [31:0] dbg_rdata,
    output logic        dbg_ack,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        timeout_err
);

    // Wait counter is at least 4 bits and wide enough to hold TIMEOUT.
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q,     state_d;
    logic              owner_q,     owner_d;
    logic              mem_we_q,    mem_we_d;
    logic [31:0]       mem_addr_q,  mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       cpu_rdata_q, cpu_rdata_d;
    logic [31:0]       dbg_rdata_q, dbg_rdata_d;
    logic [CNT_W-1:0]  wait_q,      wait_d;
    logic              timeout_q,   timeout_d;
    logic              grant_dbg;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic              last_grant_q, last_grant_d;

    // Under contention the master that was not granted last wins; the
    // register resets to debug so the first contention goes to the CPU.
    assign grant_dbg = dbg_req & (~cpu_req | (last_grant_q == OWN_CPU));
`else
    // Fixed priority: the CPU always wins contention.
    assign grant_dbg = dbg_req & ~cpu_req;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_CPU;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
            wait_q       <= '0;
            timeout_q    <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_q <= OWN_DBG;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
            wait_q       <= wait_d;
            timeout_q    <= timeout_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;
        wait_d       = wait_q;
        timeout_d    = timeout_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (cpu_req | dbg_req) begin
                    // Request fields are captured here once; later changes
                    // on the requester side have no effect on this access.
                    if (grant_dbg) begin
                        owner_d     = OWN_DBG;
                        mem_we_d    = dbg_we;
                        mem_addr_d  = dbg_addr;
                        mem_wdata_d = dbg_wdata;
                    end else begin
                        owner_d     = OWN_CPU;
                        mem_we_d    = cpu_we;
                        mem_addr_d  = cpu_addr;
                        mem_wdata_d = cpu_wdata;
                    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_grant_d = grant_dbg ? OWN_DBG : OWN_CPU;
`endif
                    wait_d  = '0;
                    state_d = ST_BUSY;
                end
            end

            ST_BUSY: begin
                if (mem_ready) begin
                    // Only reads update the owner's read-data register.
                    if (!mem_we_q) begin
                        if (owner_q == OWN_DBG) begin
                            dbg_rdata_d = mem_rdata;
                        end else begin
                            cpu_rdata_d = mem_rdata;
                        end
                    end
                    state_d = ST_DONE;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                    // This is the TIMEOUT-th cycle without an answer: give
                    // up, flag it, and still complete the handshake so the
                    // requester is not left stalled forever.
                    if (wait_q == WAIT_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_en      = (state_q == ST_BUSY);
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign dbg_rdata   = dbg_rdata_q;
    assign timeout_err = timeout_q;

    // A single owner register makes simultaneous acks impossible.
    assign cpu_ack   = (state_q == ST_DONE) && (owner_q == OWN_CPU);
    assign dbg_ack   = (state_q == ST_DONE) && (owner_q == OWN_DBG);
    assign cpu_stall = cpu_req & ~cpu_ack;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed self-checking bench for mem_arbiter. Memory side
//                (mem_ready / mem_rdata) is driven directly by the stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dbg_req, dbg_we, mem_ready;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata, mem_rdata;
    logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata;
    logic        cpu_ack, cpu_stall, dbg_ack, mem_en, mem_we, timeout_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_cpu_rdata;
    logic [31:0] exp_dbg_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ack    (cpu_ack),
        .cpu_stall  (cpu_stall),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_rdata  (dbg_rdata),
        .dbg_ack    (dbg_ack),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .timeout_err(timeout_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; return shortly after the active edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_mem_en"},    32'(mem_en),      32'd0);
        check_eq({tag, "_mem_we"},    32'(mem_we),      32'd0);
        check_eq({tag, "_mem_addr"},  mem_addr,         32'd0);
        check_eq({tag, "_mem_wdata"}, mem_wdata,        32'd0);
        check_eq({tag, "_cpu_rdata"}, cpu_rdata,        32'd0);
        check_eq({tag, "_dbg_rdata"}, dbg_rdata,        32'd0);
        check_eq({tag, "_cpu_ack"},   32'(cpu_ack),     32'd0);
        check_eq({tag, "_dbg_ack"},   32'(dbg_ack),     32'd0);
        check_eq({tag, "_timeout"},   32'(timeout_err), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;

        // ---------------- reset state ----------------
        cyc(); cyc();
        check_reset_outputs("rst");
        check_eq("rst_stall", 32'(cpu_stall), 32'd0);
        reset = 1'b0;
        cyc();

        // ---------------- CPU read, zero wait ----------------
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0004;
        mem_ready = 1'b1; mem_rdata = 32'h8C22_0000;   // ready early: ignored in IDLE
        #1;
        check_eq("rd_c0_ack",   32'(cpu_ack),   32'd0);
        check_eq("rd_c0_stall", 32'(cpu_stall), 32'd1);
        check_eq("rd_c0_mem_en", 32'(mem_en),   32'd0);
        cyc();
        check_eq("rd_c1_mem_en", 32'(mem_en),   32'd1);
        check_eq("rd_c1_addr",   mem_addr,      32'h0000_0004);
        check_eq("rd_c1_we",     32'(mem_we),   32'd0);
        check_eq("rd_c1_ack",    32'(cpu_ack),  32'd0);
        cyc();
        check_eq("rd_c2_ack",    32'(cpu_ack),   32'd1);
        check_eq("rd_c2_dbgack", 32'(dbg_ack),   32'd0);
        check_eq("rd_c2_stall",  32'(cpu_stall), 32'd0);
        check_eq("rd_c2_mem_en", 32'(mem_en),    32'd0);
        check_eq("rd_c2_rdata",  cpu_rdata,      32'h8C22_0000);
        exp_cpu_rdata = 32'h8C22_0000;
        exp_dbg_rdata = 32'h0;
        cpu_req = 1'b0; mem_ready = 1'b0;
        cyc();
        check_eq("rd_c3_ack", 32'(cpu_ack), 32'd0);

        // ---------------- debug write, 4 wait cycles ----------------
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h10; dbg_wdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (i == 0) begin
                // Fields change after latch; the memory side must not follow.
                dbg_addr = 32'hFFFF_FFF0; dbg_wdata = 32'h0BAD_0BAD;
            end
            check_eq("wr_busy_en",    32'(mem_en),  32'd1);
            check_eq("wr_busy_we",    32'(mem_we),  32'd1);
            check_eq("wr_busy_addr",  mem_addr,     32'h10);
            check_eq("wr_busy_wdata", mem_wdata,    32'hDEAD_BEEF);
            check_eq("wr_busy_ack",   32'(dbg_ack), 32'd0);
        end
        mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
        cyc();
        check_eq("wr_done_ack",    32'(dbg_ack), 32'd1);
        check_eq("wr_done_cpuack", 32'(cpu_ack), 32'd0);
        check_eq("wr_done_rdata",  dbg_rdata,    exp_dbg_rdata);
        dbg_req = 1'b0; dbg_we = 1'b0; mem_ready = 1'b0;
        cyc();
        check_eq("wr_after_ack", 32'(dbg_ack), 32'd0);

        // ---------------- contention, twice ----------------
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h30;
        mem_ready = 1'b1; mem_rdata = 32'h0000_00A1;
        cyc();
        check_eq("arb1_addr", mem_addr, 32'h20);
        cyc();
        check_eq("arb1_cpuack", 32'(cpu_ack), 32'd1);
        check_eq("arb1_dbgack", 32'(dbg_ack), 32'd0);
        check_eq("arb1_rdata",  cpu_rdata,    32'h0000_00A1);
        exp_cpu_rdata = 32'h0000_00A1;
        mem_rdata = 32'h0000_00B2;
        cyc();                                   // IDLE, both still requesting
        cyc();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        check_eq("arb2_addr", mem_addr, 32'h30);
        cyc();
        check_eq("arb2_cpuack", 32'(cpu_ack), 32'd0);
        check_eq("arb2_dbgack", 32'(dbg_ack), 32'd1);
        exp_dbg_rdata = 32'h0000_00B2;
`else
        check_eq("arb2_addr", mem_addr, 32'h20);
        cyc();
        check_eq("arb2_cpuack", 32'(cpu_ack), 32'd1);
        check_eq("arb2_dbgack", 32'(dbg_ack), 32'd0);
        exp_cpu_rdata = 32'h0000_00B2;
`endif
        check_eq("arb2_cpu_rdata", cpu_rdata, exp_cpu_rdata);
        check_eq("arb2_dbg_rdata", dbg_rdata, exp_dbg_rdata);
        cpu_req = 1'b0; dbg_req = 1'b0; mem_ready = 1'b0;
        cyc();

        // ---------------- timeout ----------------
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; mem_rdata = 32'h6666_6666;
        for (int i = 0; i < 15; i++) begin
            cyc();
            check_eq("to_busy_en",   32'(mem_en),      32'd1);
            check_eq("to_busy_flag", 32'(timeout_err), 32'd0);
            check_eq("to_busy_ack",  32'(cpu_ack),     32'd0);
        end
        cyc();
        check_eq("to_flag",   32'(timeout_err), 32'd1);
        check_eq("to_ack",    32'(cpu_ack),     32'd1);
        check_eq("to_mem_en", 32'(mem_en),      32'd0);
        check_eq("to_rdata",  cpu_rdata,        exp_cpu_rdata);
        cpu_req = 1'b0;
        cyc();
        cpu_req = 1'b1; cpu_addr = 32'h44; mem_ready = 1'b1; mem_rdata = 32'h0000_55AA;
        cyc(); cyc();
        check_eq("to_next_ack",   32'(cpu_ack),     32'd1);
        check_eq("to_next_rdata", cpu_rdata,        32'h0000_55AA);
        check_eq("to_sticky",     32'(timeout_err), 32'd1);
        cpu_req = 1'b0; mem_ready = 1'b0;
        cyc();

        // ---------------- reset during BUSY ----------------
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h80; cpu_wdata = 32'h77;
        cyc();
        check_eq("rb_busy_en", 32'(mem_en), 32'd1);
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
        cyc();
        check_reset_outputs("rb");
        reset = 1'b0;
        cyc();
        check_eq("rb_noack", 32'(cpu_ack), 32'd0);
        cpu_req = 1'b1; cpu_addr = 32'h8; mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
        cyc(); cyc();
        check_eq("rb_new_ack",   32'(cpu_ack), 32'd1);
        check_eq("rb_new_rdata", cpu_rdata,    32'h0BAD_F00D);
        cpu_req = 1'b0; mem_ready = 1'b0;
        cyc();

        // ---------------- request dropped after grant ----------------
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hC; mem_rdata = 32'h3141_5926;
        cyc();
        cpu_req = 1'b0;
        #1;
        check_eq("drop_c1_stall", 32'(cpu_stall), 32'd0);
        check_eq("drop_c1_en",    32'(mem_en),    32'd1);
        cyc();
        check_eq("drop_c2_stall", 32'(cpu_stall), 32'd0);
        check_eq("drop_c2_ack",   32'(cpu_ack),   32'd0);
        mem_ready = 1'b1;
        cyc();
        check_eq("drop_ack",   32'(cpu_ack),   32'd1);
        check_eq("drop_stall", 32'(cpu_stall), 32'd0);
        check_eq("drop_rdata", cpu_rdata,      32'h3141_5926);
        mem_ready = 1'b0;
        cyc();
        check_eq("drop_ack_once", 32'(cpu_ack),   32'd0);
        check_eq("drop_stall_end", 32'(cpu_stall), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Both acks high at once is always an error.
    always @(negedge clk) begin
        if (cpu_ack && dbg_ack) begin
            check_eq("ack_exclusive", 32'(cpu_ack & dbg_ack), 32'd0);
        end
    end

endmodule
`default_nettype wire
